alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand/accumulator width; SHALL match the attached alu instance.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has a command.
REQ-005 reqN_op  in  3  ALU opcode: HOLD=0 CLEAR=1 ADD=2 SUB=3 AND=4 NEG=5 NOT=6 XOR=7.
REQ-006 reqN_data  in  WIDTH  operand.
REQ-007 reqN_lock  in  1  keep the grant after this command.
REQ-008 reqN_ready  out  1  command accepted on this edge when reqN_valid also high.
REQ-009 alu_control  out  3  opcode to alu.control.
REQ-010 alu_in  out  WIDTH  operand to alu.in.
REQ-011 alu_accumulator  in  WIDTH  from alu.accumulator.
REQ-012 alu_flags  in  4  from alu.flags.
REQ-013 rsp_valid  out  1  response strobe, one cycle per command.
REQ-014 rsp_id  out  1  requester that owns the response.
REQ-015 rsp_result  out  WIDTH  accumulator after the command.
REQ-016 rsp_flags  out  4  ALU flags after the command.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on accept, ISSUE->RESP always, RESP->IDLE always.
REQ-019 In IDLE, reqN_ready SHALL be high only for the requester selected by the arbiter; at most one ready high per cycle; both low outside IDLE.
REQ-020 Arbitration without lock: round-robin; last-accepted requester has lower priority when both valid; a lone valid requester is selected.
REQ-021 Lock: accepting a command with lock=1 SHALL make that requester the owner; the other requester's ready stays 0 until the owner's command with lock=0 is accepted.
REQ-022 On accept, op, data and id SHALL be registered; ready is not a function of rsp or ALU outputs.
REQ-023 In ISSUE, alu_control/alu_in SHALL equal the registered op/data for exactly one cycle; in all other states alu_control=HOLD, alu_in=0.
REQ-024 In RESP, rsp_valid=1, rsp_id=registered id, rsp_result=alu_accumulator, rsp_flags=alu_flags (post-issue-edge values); rsp_result/rsp_flags are 0 when rsp_valid=0.
REQ-025 Latency: accept edge -> ISSUE cycle -> rsp_valid in next cycle; throughput one command per 3 cycles.
REQ-026 All 8 opcodes SHALL be accepted; HOLD acts as accumulator read.
REQ-027 No response backpressure; rsp_valid is a one-cycle pulse.

Reset
REQ-028 rst high SHALL immediately force: state IDLE, rsp_valid=0, rsp_id=0, busy=0, lock owner cleared, alu_control=HOLD, alu_in=0, last-grant=1 (req0 wins first tie).
REQ-029 Reset during ISSUE/RESP SHALL abort the command with no response; alu accumulator is not cleared by the sequencer.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode constants, WIDTH default and the FSM state type.
REQ-031 Sub-module rr_arbiter2 SHALL implement two-way round-robin with lock owner; FSM and datapath registers in alu_sequencer.

Verification
REQ-032 Reset, req0 CLEAR then ADD 5 -> responses id0 result 0x00, then 0x05; rsp_valid 2 cycles after each accept edge.
REQ-033 req0 and req1 both valid continuously with lock=0, ops ADD 1 -> accept order req0,req1,req0,req1; results 0x01,0x02,0x03,0x04 after CLEAR.
REQ-034 After CLEAR, req0 ADD 5 lock=1, req1 valid throughout -> req1_ready=0 until req0 SUB 3 lock=0 accepted; results 0x05, 0x02, then req1 served.
REQ-035 Accumulator 0x02, req1 HOLD -> rsp_id=1, rsp_result=0x02, accumulator unchanged.
REQ-036 rst pulsed during ISSUE -> alu_control=HOLD same cycle, no rsp_valid, busy=0; req0_ready high first IDLE cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM definitions for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [2:0] {
    OpHold  = 3'd0,
    OpClear = 3'd1,
    OpAdd   = 3'd2,
    OpSub   = 3'd3,
    OpAnd   = 3'd4,
    OpNeg   = 3'd5,
    OpNot   = 3'd6,
    OpXor   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a sticky lock owner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q;
  logic locked_q;
  logic owner_q;

  always_comb begin
    gnt = 2'b00;
    if (locked_q) begin
      gnt[owner_q] = req[owner_q];
    end else if (req == 2'b11) begin
      // Last-accepted requester yields on a tie.
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    gnt_id = gnt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
    end else if (accept) begin
      last_q   <= gnt_id;
      locked_q <= lock[gnt_id];
      owner_q  <= gnt_id;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two command requesters onto an external accumulator ALU and returns
// one response per command.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_lock,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_lock,
  output logic             req1_ready,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] alu_accumulator,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             idle;
  logic             accept;

  assign idle       = (state_q == StIdle);
  assign accept     = idle && (gnt != 2'b00);
  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .lock   ({req1_lock, req0_lock}),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpHold;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= gnt_id ? req1_op : req0_op;
        data_q <= gnt_id ? req1_data : req0_data;
        id_q   <= gnt_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_control = OpHold;
    alu_in      = '0;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    rsp_result  = '0;
    rsp_flags   = 4'h0;
    busy        = !idle;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        alu_control = op_q;
        alu_in      = data_q;
        state_d     = StResp;
      end
      StResp: begin
        // ALU outputs here already reflect the issue edge.
        rsp_valid  = 1'b1;
        rsp_id     = id_q;
        rsp_result = alu_accumulator;
        rsp_flags  = alu_flags;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench: random two-requester traffic against a behavioural model.
module tb_alu_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]   req0_op = 3'd0, req1_op = 3'd0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_lock = 1'b0, req1_lock = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_in;
  logic [W-1:0] alu_acc = '0;
  logic [3:0]   alu_flags = 4'h0;
  logic         rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_op         (req0_op),
    .req0_data       (req0_data),
    .req0_lock       (req0_lock),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_op         (req1_op),
    .req1_data       (req1_data),
    .req1_lock       (req1_lock),
    .req1_ready      (req1_ready),
    .alu_control     (alu_control),
    .alu_in          (alu_in),
    .alu_accumulator (alu_acc),
    .alu_flags       (alu_flags),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_flags       (rsp_flags),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour: returns {flags, accumulator}; flags = {zero, neg, carry, parity}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [2:0] op,
                                        input logic [7:0] d);
    int r;
    logic c;
    c = 1'b0;
    case (op)
      3'd0: r = a;
      3'd1: r = 0;
      3'd2: begin r = int'(a) + int'(d); c = (r > 255); end
      3'd3: begin r = int'(a) - int'(d); c = (r < 0); end
      3'd4: r = a & d;
      3'd5: r = 256 - int'(a);
      3'd6: r = 255 - int'(a);
      default: r = a ^ d;
    endcase
    r = r & 255;
    return {(r == 0), (r >= 128), c, ^r[7:0], r[7:0]};
  endfunction

  // External ALU stand-in; the sequencer never resets it.
  always @(posedge clk) {alu_flags, alu_acc} <= alu_f(alu_acc, alu_control, alu_in);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] result;
    logic [3:0] flags;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model state.
  logic       m_last = 1'b1;
  int         m_owner = -1;
  int         m_wait = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_acc_saved = 8'h00;
  logic [2:0] m_op;
  logic [7:0] m_data;

  task automatic step(input logic r, input logic v0, input logic [2:0] o0, input logic [7:0] d0,
                      input logic l0, input logic v1, input logic [2:0] o1,
                      input logic [7:0] d1, input logic l1);
    int g;
    logic [11:0] fr;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_op = o0; req0_data = d0; req0_lock = l0;
    req1_valid = v1; req1_op = o1; req1_data = d1; req1_lock = l1;
    #1;
    if (r) begin
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_alu_control", alu_control, 0);
      check("rst_alu_in", alu_in, 0);
      if (m_wait > 0) begin
        void'(sb.pop_back());
        m_acc = m_acc_saved;
      end
      m_wait = 0; m_last = 1'b1; m_owner = -1;
    end else if (m_wait > 0) begin
      check("busy_ready0", req0_ready, 0);
      check("busy_ready1", req1_ready, 0);
      check("busy", busy, 1);
      if (m_wait == 2) begin
        check("issue_control", alu_control, m_op);
        check("issue_in", alu_in, m_data);
      end else begin
        check("resp_control", alu_control, 0);
        check("resp_in", alu_in, 0);
      end
      m_wait--;
    end else begin
      g = -1;
      if (m_owner >= 0) g = ((m_owner == 0) ? v0 : v1) ? m_owner : -1;
      else if (v0 && v1) g = m_last ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
      check("idle_busy", busy, 0);
      check("idle_ready0", req0_ready, (g == 0));
      check("idle_ready1", req1_ready, (g == 1));
      check("idle_control", alu_control, 0);
      if (g >= 0) begin
        m_op   = (g == 0) ? o0 : o1;
        m_data = (g == 0) ? d0 : d1;
        fr = alu_f(m_acc, m_op, m_data);
        m_acc_saved = m_acc;
        m_acc = fr[7:0];
        sb.push_back('{due: cyc + 2, id: logic'(g), result: fr[7:0], flags: fr[11:8]});
        m_last = logic'(g);
        m_owner = ((g == 0) ? l0 : l1) ? g : -1;
        m_wait = 2;
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && m_wait > 0; i++) idle_step();
  endtask

  // Monitor: the scoreboard head is due on a specific cycle; nothing may appear otherwise.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          check("rsp_valid", rsp_valid, 1);
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_result", rsp_result, sb[0].result);
          check("rsp_flags", rsp_flags, sb[0].flags);
          void'(sb.pop_front());
        end else begin
          check("no_rsp_valid", rsp_valid, 0);
          check("no_rsp_result", rsp_result, 0);
          check("no_rsp_flags", rsp_flags, 0);
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 1'b1, 3'd2, 8'h22, 1'b0);
    idle_step();
    // req0 CLEAR then ADD 5.
    step(1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0); drain();
    step(1'b0, 1'b1, 3'd2, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0); drain();
    // CLEAR, then both requesters ADD 1 continuously.
    step(1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0); drain();
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 3'd2, 8'h01, 1'b0, 1'b1, 3'd2, 8'h01, 1'b0);
    drain();
    // req1 CLEAR, req0 locks with ADD 5, releases with SUB 3, then req1 HOLD.
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0); drain();
    step(1'b0, 1'b1, 3'd2, 8'h05, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0); drain();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd3, 8'h03, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0); drain();
    step(1'b0, 1'b1, 3'd2, 8'h09, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0); drain();
    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(1'b0,
           ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 3) == 0));
    drain();
    // Reset pulsed during ISSUE aborts the command.
    step(1'b0, 1'b1, 3'd2, 8'h40, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 3'd2, 8'h40, 1'b0, 1'b1, 3'd2, 8'h41, 1'b0);
    step(1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0); drain();
    for (int i = 0; i < 4; i++) idle_step();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
